parity_stream_checker: RTL
==========================

// Module: parity_stream_checker
//
// PURPOSE
// Parametrised successor to the 4-input odd-parity checker. Checks a stream of
// DATA_W-bit words, each with an attached parity bit, in runtime-selectable odd or
// even mode over a valid/ready handshake. The block registers each result with its
// data and keeps a sticky error flag and a saturating error counter. It sits between
// a parity-protected source (link or memory read path) and the consuming logic.
//
// PARAMETERS
// DATA_W  4  width of the data word, excluding the parity bit (>=1)
// CNT_W   8  width of the error counter (>=1)
//
// PORTS
// clk         in   1       system clock, rising edge
// rst_n       in   1       asynchronous active-low reset
// odd_mode    in   1       1 = odd parity expected, 0 = even parity expected
// clr         in   1       synchronous clear of err_sticky and err_count
// in_valid    in   1       input word valid
// in_ready    out  1       block can accept an input word
// in_data     in   DATA_W  input data word
// in_par      in   1       parity bit attached to in_data
// out_valid   out  1       output word valid
// out_ready   in   1       downstream can accept the output word
// out_data    out  DATA_W  registered copy of the accepted in_data
// out_err     out  1       1 = the accepted word failed the parity check
// err_sticky  out  1       set by any parity error, cleared only by clr or reset
// err_count   out  CNT_W   number of erroneous words accepted, saturating
//
// BEHAVIOUR
// - Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
// - Values while rst_n is low: out_valid=0, out_data=0, out_err=0, err_sticky=0,
//   err_count=0. in_ready follows its equation, so it is 1.
// - Reset mid-operation drops the word held in the output register. No output
//   transfer occurs for that word.
// - Storage: a single-entry output register.
// - in_ready = !out_valid || out_ready. This is combinational.
// - An accept happens on a rising edge where in_valid && in_ready.
// - On accept, the register captures in_data into out_data and the check result into
//   out_err. out_valid=1 from the next cycle. Latency is 1 cycle.
// - Parity check: ones = popcount({in_data,in_par}).
//   - Odd mode: error when ones is even.
//   - Even mode: error when ones is odd.
// - odd_mode is sampled on the accept edge only. Changing it later does not alter a
//   word already held in the output register.
// - An output transfer happens on an edge where out_valid && out_ready.
// - If a transfer occurs with no accept on the same edge, out_valid goes to 0.
//   out_data and out_err keep their last values.
// - A simultaneous transfer and accept replaces the held word. This gives full
//   throughput of one word per cycle when out_ready=1.
// - While out_valid=1 and out_ready=0, out_data and out_err stay stable and
//   in_ready=0.
// - Error statistics are updated on the accept edge of an erroneous word:
//   - err_sticky is set to 1.
//   - err_count increments by 1 and saturates at 2^CNT_W-1. It never wraps.
// - clr takes effect on its edge: err_sticky=0 and err_count=0.
// - clr on the same edge as an erroneous accept: err_sticky=1 and err_count=1. The
//   new error is not lost.
// - clr does not affect the data path.
//
// TESTING
// Odd mode, DATA_W=4: in_data=4'b0000, in_par=1
//   -> 1 cycle later out_valid=1, out_data=4'b0000, out_err=0, err_count=0.
// Odd mode: in_data=4'b0110, in_par=0
//   -> out_err=1, err_sticky=1, err_count=1.
// Even mode: in_data=4'b1011, in_par=1 -> out_err=0.
//   Then in_data=4'b1011, in_par=0 -> out_err=1.
// Backpressure: hold out_ready=0 while offering two words
//   -> first word is held stable and in_ready=0. When out_ready=1, both words
//   emerge in order with no loss or duplication.
// CNT_W=2: six consecutive erroneous words -> err_count saturates at 3.
//   Then clr coincident with a seventh error -> err_count=1, err_sticky=1.
// rst_n low while out_valid=1 -> immediately out_valid=0, err_count=0,
//   err_sticky=0, in_ready=1.

Source files
------------

// File: rtl/parity_stream_checker.sv
// parity_stream_checker
//   Checks a stream of DATA_W-bit words, each carrying one parity bit. The
//   parity sense (odd or even) is selected at runtime. Each accepted word is
//   registered with its check result in a single-entry output register behind
//   a valid/ready handshake. A sticky error flag and a saturating error
//   counter track how many bad words have been accepted.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   odd_mode              1 = odd parity expected, 0 = even; sampled on accept
//   clr                   synchronous clear of err_sticky / err_count
//   in_valid/in_ready     input handshake; in_ready = !out_valid || out_ready
//   in_data, in_par       input word and its attached parity bit
//   out_valid/out_ready   output handshake
//   out_data, out_err     registered word and its parity-fail flag
//   err_sticky            set by any accepted bad word
//   err_count             count of accepted bad words, saturating
module parity_stream_checker #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  logic             out_valid_q, out_valid_d;
  rsp_t             rsp_q, rsp_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic accept, xfer, par_err;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  // XOR-reduce gives popcount LSB: 1 means an odd number of ones.
  // Odd mode fails on an even count, even mode on an odd count.
  assign par_err  = odd_mode ? ~(^{in_data, in_par}) : (^{in_data, in_par});

  always_comb begin
    out_valid_d  = out_valid_q;
    rsp_d        = rsp_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;

    // Accept wins over transfer: a simultaneous pair replaces the held word.
    if (accept) begin
      out_valid_d = 1'b1;
      rsp_d.data  = in_data;
      rsp_d.err   = par_err;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end

    // Applied after clr so an error arriving on the clear edge still counts.
    if (accept && par_err) begin
      err_sticky_d = 1'b1;
      if (clr)
        err_count_d = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (err_count_q != {CNT_W{1'b1}})
        err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      rsp_q        <= '0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      rsp_q        <= rsp_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = rsp_q.data;
  assign out_err    = rsp_q.err;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule
